// File: rtl/adc_avg_filter_pkg.sv
// Shared mode encodings and width helper for the ADC averaging filter.
package adc_filt_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_MAVG   = 2'b01;
  localparam logic [1:0] MODE_TRIM   = 2'b10;

  function automatic int calcSw(input int dw, input int log2Depth);
    return dw + log2Depth;
  endfunction

endpackage

// File: rtl/adc_avg_filter_if.sv
// Sample/result bundle between ADC capture, the averaging filter and downstream logic.
interface adc_avg_filter_if #(parameter int DW = 14);

  logic [1:0]    mode;
  logic          clr;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          fill_done;
  logic          overrun;

  modport master (
    output mode, clr, in_valid, in_data,
    input  out_valid, out_data, fill_done, overrun
  );

  modport slave (
    input  mode, clr, in_valid, in_data,
    output out_valid, out_data, fill_done, overrun
  );

endinterface

// File: rtl/adc_avg_filter_seq_udiv.sv
// Restoring unsigned sequential divider: one quotient bit per cycle, W iterations,
// done pulses on the last iteration edge; abort returns it to idle.
module seq_udiv #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         sys_rst_n,
  input  logic         abort_i,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] quotient_o
);

  localparam int CNW = $clog2(W);
  localparam logic [CNW-1:0] LAST = CNW'(W - 1);

  logic [W-1:0]   rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [W:0]     remShift;
  logic           ge;

  // The dividend is shifted out of the quotient register MSB-first while
  // quotient bits are shifted in at the bottom.
  always_comb begin
    remShift = {rem_q, quo_q[W-1]};
    ge       = remShift >= {1'b0, div_q};
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i && !busy_q) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      div_d  = divisor_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = ge ? W'(remShift - {1'b0, div_q}) : remShift[W-1:0];
      quo_d = {quo_q[W-2:0], ge};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/adc_avg_filter.sv
// ADC sample filter: bypass, power-of-two moving average, or block trimmed mean
// (min and max dropped) with flush on clr or mode change and sticky overrun.
module adc_avg_filter
  import adc_filt_pkg::*;
#(
  parameter int DW         = 14,
  parameter int LOG2_DEPTH = 4
) (
  input logic               clk,
  input logic               sys_rst_n,
  adc_avg_filter_if.slave   bus
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = calcSw(DW, LOG2_DEPTH);
  localparam int CW    = LOG2_DEPTH + 1;
  localparam logic [CW-1:0]         FULL     = CW'(DEPTH);
  localparam logic [CW-1:0]         FULL_M1  = CW'(DEPTH - 1);
  localparam logic [LOG2_DEPTH-1:0] LAST_BLK = LOG2_DEPTH'(DEPTH - 1);
  localparam logic [SW-1:0]         TRIM_DIV = SW'(DEPTH - 2);

  logic [1:0]            mode_q;
  logic [DW-1:0]         buf_q [DEPTH];
  logic [LOG2_DEPTH-1:0] ptr_q, ptr_d, blk_q, blk_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [DW-1:0]         min_q, min_d, max_q, max_d, minNext, maxNext;
  logic                  outValid_q, outValid_d, overrun_q, overrun_d;
  logic [DW-1:0]         outData_q, outData_d;
  logic [SW-1:0]         sample, oldest, mavgSum, dividend, quot;
  logic                  flush, isMavg, isTrim, divStart, divBusy, divDone;

  assign flush  = bus.clr | (bus.mode != mode_q);
  assign isMavg = bus.mode == MODE_MAVG;
  assign isTrim = bus.mode == MODE_TRIM;

  // sum_q is shared: running window sum in moving-average mode, block sum in
  // trimmed mode; any mode change flushes it, so the two uses never mix.
  always_comb begin
    sample     = SW'(bus.in_data);
    oldest     = (fill_q == FULL) ? SW'(buf_q[ptr_q]) : '0;
    mavgSum    = sum_q + sample - oldest;
    minNext    = (bus.in_data < min_q) ? bus.in_data : min_q;
    maxNext    = (bus.in_data > max_q) ? bus.in_data : max_q;
    dividend   = sum_q + sample - SW'(minNext) - SW'(maxNext);
    ptr_d      = ptr_q;
    fill_d     = fill_q;
    blk_d      = blk_q;
    sum_d      = sum_q;
    min_d      = min_q;
    max_d      = max_q;
    overrun_d  = overrun_q;
    outValid_d = 1'b0;
    outData_d  = outData_q;
    divStart   = 1'b0;
    if (flush) begin
      ptr_d     = '0;
      fill_d    = '0;
      blk_d     = '0;
      sum_d     = '0;
      min_d     = '1;
      max_d     = '0;
      overrun_d = 1'b0;
    end else begin
      if (divDone) begin
        outValid_d = 1'b1;
        outData_d  = DW'(quot);
      end
      if (bus.in_valid) begin
        if (isMavg) begin
          ptr_d  = ptr_q + 1'b1;
          fill_d = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
          sum_d  = mavgSum;
          if (fill_q >= FULL_M1) begin
            outValid_d = 1'b1;
            outData_d  = DW'(mavgSum >> LOG2_DEPTH);
          end
        end else if (isTrim) begin
          if (blk_q == LAST_BLK) begin
            if (divBusy) overrun_d = 1'b1;
            else         divStart  = 1'b1;
            blk_d = '0;
            sum_d = '0;
            min_d = '1;
            max_d = '0;
          end else begin
            blk_d = blk_q + 1'b1;
            sum_d = sum_q + sample;
            min_d = minNext;
            max_d = maxNext;
          end
        end else begin
          outValid_d = 1'b1;
          outData_d  = bus.in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q     <= MODE_BYPASS;
      ptr_q      <= '0;
      fill_q     <= '0;
      blk_q      <= '0;
      sum_q      <= '0;
      min_q      <= '1;
      max_q      <= '0;
      overrun_q  <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      mode_q     <= bus.mode;
      ptr_q      <= ptr_d;
      fill_q     <= fill_d;
      blk_q      <= blk_d;
      sum_q      <= sum_d;
      min_q      <= min_d;
      max_q      <= max_d;
      overrun_q  <= overrun_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (bus.in_valid && isMavg) begin
      buf_q[ptr_q] <= bus.in_data;
    end
  end

  seq_udiv #(.W(SW)) uDiv (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .abort_i    (flush),
    .start_i    (divStart),
    .dividend_i (dividend),
    .divisor_i  (TRIM_DIV),
    .busy_o     (divBusy),
    .done_o     (divDone),
    .quotient_o (quot)
  );

  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.fill_done = (fill_q == FULL);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Scoreboard bench: a 16-deep filter for the main modes and a 4-deep one for overrun.
module tb_adc_avg_filter;

  logic clk;
  logic sys_rst_n;
  int   checks = 0;
  int   passes = 0;

  logic [13:0] expA[$];
  logic [13:0] expB[$];
  int          modeA = 0;
  int          win[$];
  int          blk[$];

  adc_avg_filter_if #(.DW(14)) ifA ();
  adc_avg_filter_if #(.DW(14)) ifB ();

  adc_avg_filter #(.DW(14), .LOG2_DEPTH(4)) dutA (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (ifA.slave)
  );

  adc_avg_filter #(.DW(14), .LOG2_DEPTH(2)) dutB (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (ifB.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Reference model for the 16-deep instance, run as each sample is driven.
  task automatic modelA(input int v);
    int s, mn, mx;
    if (modeA == 1) begin
      win.push_back(v);
      if (win.size() > 16) void'(win.pop_front());
      if (win.size() == 16) begin
        s = 0;
        foreach (win[i]) s += win[i];
        expA.push_back(14'(s / 16));
      end
    end else if (modeA == 2) begin
      blk.push_back(v);
      if (blk.size() == 16) begin
        s = 0; mn = 16383; mx = 0;
        foreach (blk[i]) begin
          s += blk[i];
          if (blk[i] < mn) mn = blk[i];
          if (blk[i] > mx) mx = blk[i];
        end
        expA.push_back(14'((s - mn - mx) / 14));
        blk.delete();
      end
    end else begin
      expA.push_back(14'(v));
    end
  endtask

  task automatic applyStimulus(input int v);
    @(negedge clk);
    ifA.in_valid = 1'b1;
    ifA.in_data  = 14'(v);
    modelA(v);
  endtask

  task automatic idleA(input int n);
    repeat (n) begin
      @(negedge clk);
      ifA.in_valid = 1'b0;
    end
  endtask

  // A junk sample rides on the flush edge; the filter must discard it.
  task automatic setModeA(input int m);
    @(negedge clk);
    ifA.mode     = 2'(m);
    ifA.in_valid = 1'b1;
    ifA.in_data  = 14'h1555;
    modeA = m;
    win.delete();
    blk.delete();
    @(negedge clk);
    ifA.in_valid = 1'b0;
  endtask

  task automatic clrA();
    @(negedge clk);
    ifA.clr      = 1'b1;
    ifA.in_valid = 1'b1;
    ifA.in_data  = 14'h0AAA;
    win.delete();
    blk.delete();
    @(negedge clk);
    ifA.clr      = 1'b0;
    ifA.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((expA.size() != 0 || expB.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, expA.size() + expB.size(), 0);
  endtask

  always @(negedge clk) begin : monA
    logic [13:0] e;
    if (ifA.out_valid) begin
      if (expA.size() == 0) checkOutput("A unexpected out_valid", 1, 0);
      else begin
        e = expA.pop_front();
        checkOutput("A out_data", ifA.out_data, e);
      end
    end
  end

  always @(negedge clk) begin : monB
    logic [13:0] e;
    if (ifB.out_valid) begin
      if (expB.size() == 0) checkOutput("B unexpected out_valid", 1, 0);
      else begin
        e = expB.pop_front();
        checkOutput("B out_data", ifB.out_data, e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int valsB[8] = '{8, 20, 4, 12, 1, 2, 3, 4};
    sys_rst_n = 1'b0;
    ifA.mode = 2'd0; ifA.clr = 1'b0; ifA.in_valid = 1'b0; ifA.in_data = '0;
    ifB.mode = 2'd0; ifB.clr = 1'b0; ifB.in_valid = 1'b0; ifB.in_data = '0;
    #12;
    checkOutput("reset out_valid", ifA.out_valid, 0);
    checkOutput("reset out_data", ifA.out_data, 0);
    checkOutput("reset fill_done", ifA.fill_done, 0);
    checkOutput("reset overrun", ifA.overrun, 0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    idleA(3);

    $display("[TB] moving-average fill");
    setModeA(1);
    repeat (15) applyStimulus(100);
    idleA(1);
    checkOutput("mavg fill_done partial", ifA.fill_done, 0);
    applyStimulus(100);
    idleA(1);
    checkOutput("mavg fill_done full", ifA.fill_done, 1);
    applyStimulus(1700);
    idleA(2);
    drain("mavg drain");

    $display("[TB] trimmed mean");
    setModeA(2);
    checkOutput("trim fill_done", ifA.fill_done, 0);
    repeat (7) applyStimulus(10);
    applyStimulus(16383);
    repeat (7) applyStimulus(10);
    applyStimulus(0);
    @(posedge clk);
    #1 ifA.in_valid = 1'b0;
    lat = 0;
    while (!ifA.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("trim latency", lat, 19);
    repeat (16) applyStimulus(500);
    idleA(1);
    drain("trim drain");

    $display("[TB] mode change mid-window");
    setModeA(1);
    repeat (10) applyStimulus(300);
    setModeA(2);
    checkOutput("modechg fill_done", ifA.fill_done, 0);
    for (int i = 0; i < 16; i++) applyStimulus(i * 1000 + 7);
    idleA(1);
    drain("modechg drain");

    $display("[TB] clr flush");
    setModeA(1);
    for (int i = 0; i < 20; i++) applyStimulus(50 * i + 3);
    clrA();
    checkOutput("clr fill_done", ifA.fill_done, 0);
    repeat (15) applyStimulus(800);
    idleA(1);
    checkOutput("clr refill partial", ifA.fill_done, 0);
    applyStimulus(800);
    idleA(1);
    drain("clr drain");
    checkOutput("clr refill full", ifA.fill_done, 1);

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(999);
    #2 sys_rst_n = 1'b0;
    ifA.in_valid = 1'b0;
    expA.delete();
    win.delete();
    #1;
    checkOutput("async rst out_data", ifA.out_data, 0);
    checkOutput("async rst fill_done", ifA.fill_done, 0);
    checkOutput("async rst out_valid", ifA.out_valid, 0);
    idleA(2);
    sys_rst_n = 1'b1;
    idleA(5);
    checkOutput("post rst quiet", ifA.out_valid, 0);
    repeat (16) applyStimulus(64);
    idleA(1);
    drain("post rst drain");

    $display("[TB] bypass with gaps");
    setModeA(0);
    applyStimulus(16'h3FFF);
    idleA(1);
    checkOutput("bypass latency", ifA.out_valid, 1);
    idleA(1);
    checkOutput("bypass gap", ifA.out_valid, 0);
    applyStimulus(1);
    idleA(2);
    setModeA(3);
    applyStimulus(16'h2AAA);
    idleA(2);
    drain("bypass drain");

    $display("[TB] overrun on 4-deep instance");
    @(negedge clk);
    ifB.mode = 2'd2;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) checkOutput("overrun before 2nd block", ifB.overrun, 0);
      ifB.in_valid = 1'b1;
      ifB.in_data  = 14'(valsB[i]);
      if (i == 3) expB.push_back(14'((8 + 20 + 4 + 12 - 4 - 20) / 2));
    end
    @(negedge clk);
    ifB.in_valid = 1'b0;
    checkOutput("overrun set", ifB.overrun, 1);
    drain("overrun drain");
    repeat (30) @(negedge clk);
    checkOutput("overrun sticky", ifB.overrun, 1);
    ifB.clr = 1'b1;
    @(negedge clk);
    ifB.clr = 1'b0;
    checkOutput("overrun cleared", ifB.overrun, 0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
